// File: rtl/stream_fifo_arbiter_pkg.sv
// Shared types, width helpers and the FIFO room test for the stream FIFO arbiter.
package stream_arb_pkg;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_PKT_LEN = 64;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W  = idx_w(DEF_NUM_IN);
  localparam int CNT_W = idx_w(DEF_PKT_LEN);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [CNT_W-1:0] beat_t;

  // Admit a burst only if a whole packet plus two beats of count latency still fits.
  function automatic logic room_ok(input int unsigned count,
                                   input int unsigned pkt_len,
                                   input int unsigned depth);
    return (count + pkt_len + 32'd2) <= depth;
  endfunction

endpackage

// File: rtl/stream_fifo_arbiter_rr_pick.sv
// Cyclic priority encoder: first asserted request at or after ptr_i, wrapping.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int IDX_W  = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              any_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [IDX_W-1:0] pos;

  assign any_o = |req_i;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    idx_o = ptr_i;
    pos   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr_i) + k) % NUM_IN);
      if (req_i[pos]) idx_o = pos;
    end
  end

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Round-robin burst arbiter feeding one shared FIFO from NUM_IN AXI-Stream producers.
module stream_fifo_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int WIDTH   = 256,
  parameter int DEPTH   = 16384,
  parameter int COUNT_W = 14,
  parameter int PKT_LEN = DEF_PKT_LEN,
  parameter int TIMEOUT = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_IN*WIDTH-1:0]   in_TDATA,
  input  logic [NUM_IN-1:0]         in_TVALID,
  output logic [NUM_IN-1:0]         in_TREADY,
  output logic [WIDTH-1:0]          fifo_TDATA,
  output logic                      fifo_TVALID,
  input  logic                      fifo_TREADY,
  input  logic [COUNT_W-1:0]        fifo_count,
  output logic [idx_w(NUM_IN)-1:0]  grant_id,
  output logic                      busy
);

  localparam int GID_W  = idx_w(NUM_IN);
  localparam int BEAT_W = idx_w(PKT_LEN);
  localparam int IDLE_W = idx_w(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [GID_W-1:0]   ptr_q, ptr_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;

  logic               pick_any;
  logic [GID_W-1:0]   pick_idx;
  logic               in_burst;
  logic               g_valid;
  logic               beat;
  logic               room;
  logic               done;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (GID_W)
  ) u_pick (
    .req_i  (in_TVALID),
    .ptr_i  (ptr_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign in_burst = (state_q == BURST);
  assign g_valid  = in_TVALID[grant_q];
  assign beat     = in_burst & g_valid & fifo_TREADY;
  assign room     = room_ok(32'(fifo_count), PKT_LEN, DEPTH);

  // Zero-latency pass-through of the granted producer.
  assign fifo_TDATA  = in_TDATA[int'(grant_q)*WIDTH +: WIDTH];
  assign fifo_TVALID = in_burst & g_valid;
  assign grant_id    = grant_q;
  assign busy        = in_burst;

  always_comb begin
    in_TREADY = '0;
    if (in_burst) in_TREADY[grant_q] = fifo_TREADY;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    done    = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_any && room) begin
          state_d = BURST;
          grant_d = pick_idx;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      BURST: begin
        if (beat) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
          done   = (beat_q == LAST_BEAT);
        end else if (!g_valid && TIMEOUT != 0) begin
          // Release as soon as the idle run reaches the limit, not one cycle later.
          if (idle_q != IDLE_LIMIT) idle_d = idle_q + 1'b1;
          done = (idle_d == IDLE_LIMIT);
        end
        if (done) begin
          state_d = ARB;
          ptr_d   = (grant_q == GID_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (ap_rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Directed scenarios plus randomized traffic against a burst-level model of the arbiter.
module tb_stream_fifo_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 16384;
  localparam int CW    = 14;
  localparam int PL    = 4;
  localparam int TO    = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic [N*W-1:0]   in_TDATA = '0;
  logic [N-1:0]     in_TVALID = '0;
  logic [N-1:0]     in_TREADY;
  logic [W-1:0]     fifo_TDATA;
  logic             fifo_TVALID;
  logic             fifo_TREADY = 1'b1;
  logic [CW-1:0]    fifo_count = '0;
  logic [1:0]       grant_id;
  logic             busy;

  always #5 ap_clk = ~ap_clk;

  stream_fifo_arbiter #(
    .NUM_IN  (N),
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .COUNT_W (CW),
    .PKT_LEN (PL),
    .TIMEOUT (TO)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_TDATA    (in_TDATA),
    .in_TVALID   (in_TVALID),
    .in_TREADY   (in_TREADY),
    .fifo_TDATA  (fifo_TDATA),
    .fifo_TVALID (fifo_TVALID),
    .fifo_TREADY (fifo_TREADY),
    .fifo_count  (fifo_count),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq [N];
  logic [N-1:0] want = '0;
  int          hs_cnt = 0;

  // Burst-level reference: who owns the FIFO, how many beats sent, idle run, next priority.
  bit m_known = 0;
  bit m_open  = 0;
  int m_owner = 0;
  int m_sent  = 0;
  int m_idle  = 0;
  int m_ptr   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int p, input int s);
    return {8'(p), 24'(s)};
  endfunction

  task automatic drive();
    in_TVALID = want;
    for (int i = 0; i < N; i++) in_TDATA[i*W +: W] = word(i, seq[i]);
  endtask

  task automatic cycle();
    logic [N-1:0] e_ready;
    logic         e_valid;
    int           win;
    bit           room;
    bit           hs;
    drive();
    @(negedge ap_clk);
    e_valid = m_open && want[m_owner];
    e_ready = m_open ? (N'(fifo_TREADY) << m_owner) : '0;
    if (m_known) begin
      check("busy", busy, m_open);
      check("fifo_valid", fifo_TVALID, e_valid);
      check("in_ready", in_TREADY, e_ready);
      if (m_open) check("grant_id", grant_id, m_owner);
      if (e_valid) check("fifo_data", fifo_TDATA, word(m_owner, seq[m_owner]));
    end
    if (fifo_TVALID && fifo_TREADY) hs_cnt++;
    hs = m_open && want[m_owner] && fifo_TREADY;
    if (hs) seq[m_owner]++;
    if (ap_rst) begin
      m_open = 0; m_owner = 0; m_sent = 0; m_idle = 0; m_ptr = 0; m_known = 1;
    end else if (!m_open) begin
      room = (int'(fifo_count) + PL + 2) <= DEPTH;
      if (want != '0 && room) begin
        win = m_ptr;
        while (!want[win]) win = (win + 1) % N;
        m_open = 1; m_owner = win; m_sent = 0; m_idle = 0;
      end
    end else if (hs) begin
      m_sent++;
      m_idle = 0;
      if (m_sent == PL) begin m_open = 0; m_ptr = (m_owner + 1) % N; end
    end else if (!want[m_owner]) begin
      m_idle++;
      if (TO != 0 && m_idle == TO) begin m_open = 0; m_ptr = (m_owner + 1) % N; end
    end
    @(posedge ap_clk);
    #1;
    drive();
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] on;
    int           r;
    bit           ended;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset state.
    ap_rst = 1'b1; want = '0; fifo_TREADY = 1'b1; fifo_count = '0;
    cycle();
    cycle();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", fifo_TVALID, 1'b0);
    check("rst_ready", in_TREADY, '0);
    check("rst_gid", grant_id, 0);

    // Single requester: producer 2, four beats, one bubble, regrant.
    ap_rst = 1'b0; want = 4'b0100;
    cycle();
    check("single_busy", busy, 1'b1);
    check("single_gid", grant_id, 2);
    check("single_first", fifo_TDATA, word(2, 0));
    for (int b = 0; b < PL; b++) begin
      cycle();
      check("single_burst", busy, (b < PL - 1) ? 1'b1 : 1'b0);
    end
    cycle();
    check("single_regrant", busy, 1'b1);
    check("single_regid", grant_id, 2);

    // All requesting: grants 0,1,2,3,0 with 4-beat bursts and 1-cycle gaps.
    do_reset();
    want = 4'b1111;
    cycle();
    for (int c = 0; c < 25; c++) begin
      check("rr_busy", busy, (c % 5 != 4) ? 1'b1 : 1'b0);
      if (c % 5 != 4) check("rr_gid", grant_id, (c / 5) % N);
      cycle();
    end

    // Room gate: count + PKT_LEN + 2 must not exceed DEPTH.
    do_reset();
    want = 4'b0001; fifo_count = CW'(DEPTH - PL - 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("room_block", busy, 1'b0);
      check("room_ready", in_TREADY, '0);
    end
    fifo_count = CW'(DEPTH - PL - 2);
    cycle();
    check("room_grant", busy, 1'b1);
    fifo_count = CW'(DEPTH - 1);
    cycle();
    check("room_ignored", busy, 1'b1);
    fifo_count = '0;

    // Backpressure: ready toggles, burst ends after exactly PKT_LEN transfers.
    do_reset();
    want = 4'b0001; fifo_TREADY = 1'b1;
    cycle();
    hs_cnt = 0;
    ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      fifo_TREADY = (i % 2 == 0);
      cycle();
      if (!busy) ended = 1;
    end
    check("bp_ended", ended, 1'b1);
    check("bp_beats", hs_cnt, PL);
    fifo_TREADY = 1'b1;

    // Timeout: producer 0 stalls after 2 beats; producer 1 takes over.
    do_reset();
    want = 4'b0011;
    cycle();
    cycle();
    cycle();
    want = 4'b0010;
    for (int i = 1; i <= TO; i++) begin
      cycle();
      if (i == TO - 1) check("to_hold", busy, 1'b1);
      if (i == TO) check("to_release", busy, 1'b0);
    end
    cycle();
    check("to_next_busy", busy, 1'b1);
    check("to_next_gid", grant_id, 1);

    // Reset at beat 3 of a burst.
    do_reset();
    want = 4'b1111;
    cycle();
    cycle();
    cycle();
    ap_rst = 1'b1;
    cycle();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", fifo_TVALID, 1'b0);
    check("mid_rst_ready", in_TREADY, '0);
    ap_rst = 1'b0;
    cycle();
    check("mid_rst_regrant", busy, 1'b1);
    check("mid_rst_gid", grant_id, 0);

    // Randomized traffic with long producer silences to exercise early release.
    on = 4'b1111;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) on[i] = ~on[i];
        want[i] = on[i] & ($urandom_range(0, 7) != 0);
      end
      fifo_TREADY = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      fifo_count = (r < 7) ? CW'($urandom_range(0, 1000)) : CW'($urandom_range(DEPTH - 14, DEPTH - 1));
      ap_rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    ap_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
